irq_ack_sequencer: RTL and testbench
====================================

Name: irq_ack_sequencer

Overview:
- Clocked Mode-2 interrupt-acknowledge controller for the Dock IRQ path.
- Synchronises slot INT lines and detects CPU ACK cycles.
- Grants the acknowledge to one claimant slot per cycle using per-channel round-robin, holds that slot's INT_ACK for the bus ACK window, and aborts on a timeout.
- Replaces the "unique claimant only" combinational resolution: multiple simultaneous claimants are serviced in turn instead of being dropped.

Parameters:
- NUM_IRQ_SLOTS, 4, number of slots with INT_CH0..1 (1..8).
- SLOT_W, 3, width of the slot index.
- ACK_TIMEOUT, 255, maximum cycles INT_ACK is held before abort (1..65535).
- CNT_W, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- slot_int_n  in  NUM_IRQ_SLOTS*2  slot INT lines, active-low, asynchronous; bit index = slot*2+chan.
- cpu_ack_n  in  2  CPU ACK0/ACK1, active-low, synchronous to clk.
- int_ack_mode_en  in  1  Mode-2 acknowledge enable.
- timeout_clr  in  1  clears timeout_sticky.
- slot_int_ack_n  out  NUM_IRQ_SLOTS*2  per-slot/channel INT_ACK, active-low, registered; same indexing as slot_int_n.
- ack_busy  out  1  sequencer not in IDLE.
- ack_chan  out  1  latched channel of the current cycle.
- ack_slot  out  SLOT_W  granted slot.
- ack_slot_valid  out  1  a slot is granted; INT_ACK is driven.
- ack_none  out  1  no claimant for this ACK; the bus drives the default vector.
- ack_timeout  out  1  one-cycle pulse on abort.
- timeout_sticky  out  1  latched timeout indication.

Behaviour:
- Reset values: all slot_int_ack_n = 1. ack_busy, ack_chan, ack_slot, ack_slot_valid, ack_none, ack_timeout, timeout_sticky = 0. Round-robin pointers rr_ptr[0..1] = 0. Synchroniser flops = 1. FSM = IDLE. Timeout counter = 0.
- Synchroniser: slot_int_n passes through 2-flop synchronisers to give int_s, with 2 cycles of latency. cpu_ack_n is used directly.
- Request: req = int_ack_mode_en & (~cpu_ack_n[0] | ~cpu_ack_n[1]). Channel 0 wins when both ACK lines are low.
- IDLE:
  - When req is true, latch ack_chan, set ack_busy=1 and go to ARB.
  - A request already asserted at reset release is accepted.
- ARB (exactly 1 cycle):
  - claim[s] = ~int_s[s*2+ack_chan].
  - If claim is nonzero, grant the first claimant found by searching upward from rr_ptr[ack_chan], wrapping at NUM_IRQ_SLOTS. Then set ack_slot, ack_slot_valid=1, drive slot_int_ack_n[ack_slot*2+ack_chan]=0, clear the counter and go to ACK.
  - If claim is zero, set ack_none=1 and go to WAIT_REL.
- ACK:
  - INT_ACK is held low and the counter increments each cycle.
  - Release: cpu_ack_n[ack_chan]=1 → INT_ACK=1 and ack_slot_valid=0 on the next edge. rr_ptr[ack_chan] = ack_slot+1 (wraps to 0 after NUM_IRQ_SLOTS-1). Go to IDLE.
  - Timeout: counter reaches ACK_TIMEOUT while ACK is still asserted → INT_ACK=1, ack_slot_valid=0, ack_timeout=1 for one cycle, timeout_sticky=1. rr_ptr advances as on release. Go to WAIT_REL.
  - Mode drop: int_ack_mode_en=0 → INT_ACK=1 on the next edge and go to WAIT_REL. No timeout is flagged and rr_ptr is not advanced.
- WAIT_REL:
  - Outputs are inactive except ack_none, which holds its value.
  - When cpu_ack_n[ack_chan]=1, clear ack_none and ack_busy and go to IDLE.
- Exclusivity: at most one slot_int_ack_n bit is low at any time. No INT_ACK is driven outside ACK.
- Claimant changes: a claimant deasserting INT during ACK does not change the grant. A new CPU ACK on the other channel during a cycle is ignored until IDLE.
- timeout_sticky: timeout_clr clears it. A new timeout in the same cycle as timeout_clr wins (sticky stays 1).
- Reset: asserting rst_n mid-cycle returns every output and flop to its reset value immediately.

Test Plan:
- Single claimant: slot 2 holds INT_CH0 low; after 3 cycles cpu_ack_n=2'b10 for 6 cycles → ARB at +1 cycle, slot_int_ack_n bit 4 low at +2, ack_slot=2, ack_slot_valid=1; released 1 cycle after ACK high; rr_ptr[0]=3.
- Round-robin: slots 0,1,3 all hold INT_CH1 low; three ACK1 cycles → grants 0, 1, 3 in order; a fourth cycle grants 0 (wrap).
- No claimant: all INT high, cpu_ack_n=2'b10 → ack_none=1 from ARB until release; no slot_int_ack_n bit ever low.
- Timeout: ACK_TIMEOUT=8, claimant slot 1, cpu_ack_n[0] held low 20 cycles → INT_ACK low for 8 cycles, ack_timeout pulses once, timeout_sticky=1, ack_busy=1 until ACK release; timeout_clr → sticky=0.
- Priority/mode: cpu_ack_n=2'b00 with claimants on both channels → ack_chan=0. With int_ack_mode_en=0 → ack_busy stays 0. Dropping the enable mid-ACK → INT_ACK high next cycle and ack_timeout=0.
- Reset mid-ACK: rst_n low while INT_ACK is low → all slot_int_ack_n=1 asynchronously and rr_ptr=0.

Source files
------------

// File: rtl/irq_ack_if.sv
// Mode-2 interrupt-acknowledge bus bundle.
// master drives slot INT / CPU ACK, slave drives INT_ACK and status.
interface irq_ack_if #(
  parameter int NUM_IRQ_SLOTS = 4,
  parameter int SLOT_W        = 3
);
  logic [NUM_IRQ_SLOTS*2-1:0] slot_int_n;
  logic [1:0]                 cpu_ack_n;
  logic                       int_ack_mode_en;
  logic                       timeout_clr;
  logic [NUM_IRQ_SLOTS*2-1:0] slot_int_ack_n;
  logic                       ack_busy;
  logic                       ack_chan;
  logic [SLOT_W-1:0]          ack_slot;
  logic                       ack_slot_valid;
  logic                       ack_none;
  logic                       ack_timeout;
  logic                       timeout_sticky;

  modport master (
    output slot_int_n,
    output cpu_ack_n,
    output int_ack_mode_en,
    output timeout_clr,
    input  slot_int_ack_n,
    input  ack_busy,
    input  ack_chan,
    input  ack_slot,
    input  ack_slot_valid,
    input  ack_none,
    input  ack_timeout,
    input  timeout_sticky
  );

  modport slave (
    input  slot_int_n,
    input  cpu_ack_n,
    input  int_ack_mode_en,
    input  timeout_clr,
    output slot_int_ack_n,
    output ack_busy,
    output ack_chan,
    output ack_slot,
    output ack_slot_valid,
    output ack_none,
    output ack_timeout,
    output timeout_sticky
  );
endinterface

// File: rtl/irq_ack_sequencer.sv
// Mode-2 interrupt-acknowledge sequencer for the Dock IRQ path.
// Round-robin grant per channel, held INT_ACK window, timeout abort.
module irq_ack_sequencer #(
  parameter int NUM_IRQ_SLOTS = 4,
  parameter int SLOT_W        = 3,
  parameter int ACK_TIMEOUT   = 255,
  parameter int CNT_W         = 16
) (
  input logic clk,
  input logic rst_n,
  irq_ack_if.slave bus
);

  localparam int NW = NUM_IRQ_SLOTS * 2;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ACK,
    WAIT_REL
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0]            sync_q;
  logic [NW-1:0]            int_s;
  logic [NW-1:0]            ack_n_q, ack_n_d;
  logic                     busy_q, busy_d;
  logic                     chan_q, chan_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic                     valid_q, valid_d;
  logic                     none_q, none_d;
  logic                     to_q, to_d;
  logic                     sticky_q, sticky_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SLOT_W-1:0]        rr_q [2];
  logic [SLOT_W-1:0]        rr_d [2];

  logic                     req;
  logic                     rel;
  logic [NUM_IRQ_SLOTS-1:0] claim;
  logic [SLOT_W-1:0]        ptr;
  logic [SLOT_W-1:0]        gnt;
  logic [SLOT_W-1:0]        gnt_lo;
  logic [SLOT_W-1:0]        gnt_hi;
  logic                     hi_any;
  logic [SLOT_W-1:0]        nxt_ptr;
  logic [CNT_W-1:0]         cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      int_s  <= '1;
    end else begin
      sync_q <= bus.slot_int_n;
      int_s  <= sync_q;
    end
  end

  assign req = bus.int_ack_mode_en
             & ~(&bus.cpu_ack_n);
  assign rel = bus.cpu_ack_n[chan_q];
  assign ptr = rr_q[chan_q];
  assign cnt_inc = cnt_q + 1'b1;

  assign nxt_ptr =
    (slot_q == SLOT_W'(NUM_IRQ_SLOTS - 1))
      ? '0 : slot_q + 1'b1;

  always_comb begin
    claim = '0;
    for (int s = 0; s < NUM_IRQ_SLOTS; s++) begin
      if (chan_q) claim[s] = ~int_s[2*s+1];
      else        claim[s] = ~int_s[2*s];
    end
  end

  // Lowest claimant at/above the pointer, else lowest overall (wrap).
  always_comb begin
    gnt_lo = '0;
    gnt_hi = '0;
    hi_any = 1'b0;
    for (int s = NUM_IRQ_SLOTS - 1; s >= 0; s--) begin
      if (claim[s]) gnt_lo = SLOT_W'(s);
      if (claim[s] && SLOT_W'(s) >= ptr) begin
        gnt_hi = SLOT_W'(s);
        hi_any = 1'b1;
      end
    end
    gnt = hi_any ? gnt_hi : gnt_lo;
  end

  always_comb begin
    state_d  = state_q;
    ack_n_d  = '1;
    busy_d   = busy_q;
    chan_d   = chan_q;
    slot_d   = slot_q;
    valid_d  = 1'b0;
    none_d   = 1'b0;
    to_d     = 1'b0;
    sticky_d = bus.timeout_clr ? 1'b0 : sticky_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          chan_d  = bus.cpu_ack_n[0];
          busy_d  = 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        if (|claim) begin
          slot_d  = gnt;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ACK;
          for (int s = 0; s < NUM_IRQ_SLOTS; s++) begin
            if (gnt == SLOT_W'(s)) begin
              if (chan_q) ack_n_d[2*s+1] = 1'b0;
              else        ack_n_d[2*s]   = 1'b0;
            end
          end
        end else begin
          none_d  = 1'b1;
          state_d = WAIT_REL;
        end
      end
      ACK: begin
        cnt_d = cnt_inc;
        if (rel) begin
          rr_d[chan_q] = nxt_ptr;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (!bus.int_ack_mode_en) begin
          state_d = WAIT_REL;
        end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
          rr_d[chan_q] = nxt_ptr;
          to_d         = 1'b1;
          sticky_d     = 1'b1;
          state_d      = WAIT_REL;
        end else begin
          valid_d = 1'b1;
          ack_n_d = ack_n_q;
        end
      end
      WAIT_REL: begin
        none_d = none_q;
        if (rel) begin
          none_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_n_q  <= '1;
      busy_q   <= 1'b0;
      chan_q   <= 1'b0;
      slot_q   <= '0;
      valid_q  <= 1'b0;
      none_q   <= 1'b0;
      to_q     <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      rr_q[0]  <= '0;
      rr_q[1]  <= '0;
    end else begin
      ack_n_q  <= ack_n_d;
      busy_q   <= busy_d;
      chan_q   <= chan_d;
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      none_q   <= none_d;
      to_q     <= to_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      rr_q[0]  <= rr_d[0];
      rr_q[1]  <= rr_d[1];
    end
  end

  assign bus.slot_int_ack_n = ack_n_q;
  assign bus.ack_busy       = busy_q;
  assign bus.ack_chan       = chan_q;
  assign bus.ack_slot       = slot_q;
  assign bus.ack_slot_valid = valid_q;
  assign bus.ack_none       = none_q;
  assign bus.ack_timeout    = to_q;
  assign bus.timeout_sticky = sticky_q;

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Scoreboard bench for irq_ack_sequencer: random ACK cycles vs. a
// transaction-level model of grant order, hold length and timeout.
module tb_irq_ack_sequencer;

  localparam int N = 4;
  localparam int T = 8;

  typedef struct {
    int chan;
    bit none;
    int slot;
    int to;
    int low;
    int busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  irq_ack_if #(.NUM_IRQ_SLOTS(N), .SLOT_W(3)) bus ();

  irq_ack_sequencer #(
    .NUM_IRQ_SLOTS(N),
    .SLOT_W(3),
    .ACK_TIMEOUT(T),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   rr[2];
  bit   sticky;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic int rr_pick(input logic [7:0] pat, input int ch,
                                 input int ptr);
    int sl;
    for (int i = 0; i < N; i++) begin
      sl = (ptr + i) % N;
      if (pat[sl*2+ch] == 1'b0) return sl;
    end
    return -1;
  endfunction

  // Monitor: one observed record per busy period, compared on busy fall.
  bit in_txn = 0;
  int o_chan, o_slot, o_to, o_low, o_busy;
  bit o_none;

  always @(negedge clk) begin
    int   zeros;
    int   zi;
    exp_t e;
    if (!rst_n) begin
      in_txn = 0;
    end else begin
      zeros = 0;
      zi = -1;
      for (int i = 0; i < 2*N; i++)
        if (!bus.slot_int_ack_n[i]) begin
          zeros++;
          zi = i;
        end
      chk("excl", int'(zeros <= 1), 1);
      if (zeros == 1)
        chk("ack_map", zi,
            bus.ack_slot_valid ? 2*int'(bus.ack_slot) + int'(bus.ack_chan)
                               : -1);
      if (bus.ack_busy && !in_txn) begin
        in_txn = 1;
        o_chan = int'(bus.ack_chan);
        o_slot = -1;
        o_to = 0;
        o_low = 0;
        o_busy = 0;
        o_none = 0;
      end
      if (in_txn) begin
        if (bus.ack_busy) o_busy++;
        if (zeros == 1) begin
          o_low++;
          o_slot = zi / 2;
        end
        if (bus.ack_none) o_none = 1;
        if (bus.ack_timeout) o_to++;
        if (!bus.ack_busy) begin
          in_txn = 0;
          if (q.size() == 0) begin
            chk("unexpected_txn", 1, 0);
          end else begin
            e = q.pop_front();
            chk("chan", o_chan, e.chan);
            chk("none", int'(o_none), int'(e.none));
            chk("slot", o_slot, e.slot);
            chk("timeout_pulses", o_to, e.to);
            chk("ack_low_cycles", o_low, e.low);
            chk("busy_cycles", o_busy, e.busy);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.ack_busy && n < 60) begin
      step();
      n++;
    end
    if (bus.ack_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_txn(input logic [7:0] pat, input logic [1:0] code,
                         input int h, input bit drop, input int d,
                         input bit clr_at_to, input bit int_drop);
    exp_t e;
    int   ch;
    int   s;
    bus.slot_int_n = pat;
    repeat (4) step();
    ch = (code[0] == 1'b0) ? 0 : 1;
    s = rr_pick(pat, ch, rr[ch]);
    e.chan = ch;
    e.none = (s < 0);
    e.slot = s;
    e.to = 0;
    e.low = 0;
    e.busy = h;
    if (s >= 0) begin
      if (drop) begin
        e.low = d - 1;
      end else begin
        if (h >= T + 2) begin
          e.to = 1;
          e.low = T;
        end else begin
          e.low = h - 1;
        end
        rr[ch] = (s + 1) % N;
      end
    end
    if (e.to != 0) sticky = 1;
    q.push_back(e);
    bus.cpu_ack_n = code;
    for (int k = 0; k < h; k++) begin
      bus.int_ack_mode_en = !(drop && k >= d);
      bus.timeout_clr = clr_at_to && (k == T + 1);
      if (int_drop && k == 2) bus.slot_int_n = '1;
      step();
    end
    bus.cpu_ack_n = 2'b11;
    bus.int_ack_mode_en = 1'b1;
    bus.timeout_clr = 1'b0;
    wait_idle();
    step();
    step();
    chk("sticky", int'(bus.timeout_sticky), int'(sticky));
  endtask

  task automatic clr_sticky();
    bus.timeout_clr = 1'b1;
    step();
    bus.timeout_clr = 1'b0;
    sticky = 0;
    chk("sticky_clr", int'(bus.timeout_sticky), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=0 want=1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [1:0] code;
    int         h, d, n, c;
    bit         drop;
    rr[0] = 0;
    rr[1] = 0;
    sticky = 0;
    bus.slot_int_n = '1;
    bus.cpu_ack_n = 2'b11;
    bus.int_ack_mode_en = 1'b1;
    bus.timeout_clr = 1'b0;
    repeat (3) step();
    chk("rst_ack_n", int'(bus.slot_int_ack_n), 8'hFF);
    chk("rst_status", int'({bus.ack_busy, bus.ack_chan, bus.ack_slot,
        bus.ack_slot_valid, bus.ack_none, bus.ack_timeout,
        bus.timeout_sticky}), 0);
    rst_n = 1'b1;
    step();

    // single claimant, round robin with wrap, no claimant
    run_txn(8'b1110_1111, 2'b10, 6, 0, 0, 0, 0);
    repeat (4) run_txn(8'b0111_0101, 2'b01, 4, 0, 0, 0, 0);
    run_txn(8'hFF, 2'b10, 5, 0, 0, 0, 0);
    // timeout with a clear landing on the timeout edge, then clear
    run_txn(8'b1111_1011, 2'b10, 20, 0, 0, 1, 0);
    clr_sticky();
    // both ACKs low, claimants on both channels
    run_txn(8'h00, 2'b00, 4, 0, 0, 0, 0);
    // mode disabled: no cycle starts
    bus.slot_int_n = 8'h00;
    bus.int_ack_mode_en = 1'b0;
    bus.cpu_ack_n = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mode_off_busy", int'(bus.ack_busy), 0);
    end
    bus.cpu_ack_n = 2'b11;
    bus.int_ack_mode_en = 1'b1;
    step();
    // enable dropped mid-ACK
    run_txn(8'b1111_1110, 2'b10, 10, 1, 4, 0, 0);

    for (int t = 0; t < 60; t++) begin
      pat = 8'($urandom);
      if ($urandom_range(5) == 0) pat = 8'hFF;
      c = $urandom_range(2);
      code = (c == 0) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00;
      h = $urandom_range(2, 14);
      drop = (h >= 3) && ($urandom_range(5) == 0);
      d = 0;
      if (drop) d = $urandom_range(2, (h - 1 < T + 1) ? h - 1 : T + 1);
      run_txn(pat, code, h, drop, d, 0, $urandom_range(3) == 0);
      if ($urandom_range(1) == 1) clr_sticky();
    end

    // reset mid-ACK: pointer must return to 0
    run_txn(8'b1111_1011, 2'b10, 4, 0, 0, 0, 0);
    bus.slot_int_n = 8'b1011_1110;
    repeat (4) step();
    bus.cpu_ack_n = 2'b10;
    n = 0;
    while (bus.slot_int_ack_n == 8'hFF && n < 20) begin
      step();
      n++;
    end
    chk("reset_test_ack_seen", int'(bus.slot_int_ack_n != 8'hFF), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack_n", int'(bus.slot_int_ack_n), 8'hFF);
    chk("async_rst_busy", int'({bus.ack_busy, bus.ack_slot_valid}), 0);
    bus.cpu_ack_n = 2'b11;
    repeat (2) step();
    rst_n = 1'b1;
    rr[0] = 0;
    rr[1] = 0;
    sticky = 0;
    run_txn(8'b1011_1110, 2'b10, 4, 0, 0, 0, 0);

    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
